load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/cnn_pkg.sv | 15 +
 rtl/load_addr_gen.sv | 41 ++++
 rtl/load_unit.sv | 111 +++++++++++
 tb/tb_load_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared sizing constants and FSM state type for the CNN tile loader.
package cnn_pkg;

  localparam int DATA_SZ   = 16;
  localparam int ADDR_SZ   = 16;
  localparam int BUF_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/load_addr_gen.sv
// Read-issue side of the tile loader: latches the tile base address, counts
// accepted reads and drives memRead/memAddr under memReady back-pressure.
module load_addr_gen #(
  parameter int ADDR_SZ = cnn_pkg::ADDR_SZ,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [ADDR_SZ-1:0] i_base,
  input  logic [CNT_W-1:0]   i_count,
  input  logic               i_fetch,
  input  logic               memReady,
  output logic               memRead,
  output logic [ADDR_SZ-1:0] memAddr,
  output logic               o_issue_last
);

  logic [ADDR_SZ-1:0] r_base;
  logic [CNT_W-1:0]   r_issued;
  logic               w_fire;

  assign memRead      = i_fetch;
  assign w_fire       = i_fetch && memReady;
  // Address wraps modulo 2^ADDR_SZ by plain truncation of the sum.
  assign memAddr      = r_base + ADDR_SZ'(r_issued);
  assign o_issue_last = w_fire && ((r_issued + CNT_W'(1)) == i_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base   <= '0;
      r_issued <= '0;
    end else if (i_start) begin
      r_base   <= i_base;
      r_issued <= '0;
    end else if (w_fire) begin
      r_issued <= r_issued + CNT_W'(1);
    end
  end

endmodule

// File: rtl/load_unit.sv
// Tile loader: fetches an N*N row-major tile into loadOut, one tile in flight.
// Optional build macro LOAD_ZERO_FILL_EN clears the whole buffer on request.
//
//   state    | meaning
//   ST_IDLE  | waiting for loadEnable
//   ST_FETCH | issuing reads, collecting responses
//   ST_DRAIN | all reads issued, waiting for remaining responses
//   ST_DONE  | one-cycle loadDone pulse
module load_unit #(
  parameter int DATA_SZ   = cnn_pkg::DATA_SZ,
  parameter int ADDR_SZ   = cnn_pkg::ADDR_SZ,
  parameter int BUF_DEPTH = cnn_pkg::BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_SZ-1:0]        loadAddr,
  input  logic [DATA_SZ-1:0]        loadSize,
  output logic signed [DATA_SZ-1:0] loadOut [0:BUF_DEPTH-1],
  output logic                      loadDone,
  output logic                      busy,
  output logic [ADDR_SZ-1:0]        memAddr,
  output logic                      memRead,
  input  logic                      memReady,
  input  logic signed [DATA_SZ-1:0] memData,
  input  logic                      memValid
);
  import cnn_pkg::*;

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int SQ_W  = 2 * DATA_SZ;

  load_state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_count, r_received, w_count_req;
  logic [SQ_W-1:0]           w_sq;
  logic                      w_accept, w_fetch, w_issue_last, w_resp_wr, w_recv_last;
  logic signed [DATA_SZ-1:0] r_buf [0:BUF_DEPTH-1];

  assign w_sq        = SQ_W'(loadSize) * SQ_W'(loadSize);
  assign w_count_req = (w_sq > SQ_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : CNT_W'(w_sq);

  assign w_accept    = (r_state == ST_IDLE) && loadEnable;
  assign w_fetch     = (r_state == ST_FETCH);
  // Responses beyond the tile size, or outside an active load, are dropped.
  assign w_resp_wr   = memValid && ((r_state == ST_FETCH) || (r_state == ST_DRAIN))
                       && (r_received < r_count);
  assign w_recv_last = w_resp_wr && ((r_received + CNT_W'(1)) == r_count);

  assign loadDone = (r_state == ST_DONE);
  assign busy     = (r_state != ST_IDLE);
  assign loadOut  = r_buf;

  load_addr_gen #(
    .ADDR_SZ (ADDR_SZ),
    .CNT_W   (CNT_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_accept),
    .i_base       (loadAddr),
    .i_count      (r_count),
    .i_fetch      (w_fetch),
    .memReady     (memReady),
    .memRead      (memRead),
    .memAddr      (memAddr),
    .o_issue_last (w_issue_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (loadEnable) w_state_nxt = (loadSize == '0) ? ST_DONE : ST_FETCH;
      // Final issue and final response can coincide, skipping DRAIN.
      ST_FETCH: if (w_issue_last) w_state_nxt = w_recv_last ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_recv_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_received <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_count    <= w_count_req;
        r_received <= '0;
      end else if (w_resp_wr) begin
        r_received <= r_received + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
`ifdef LOAD_ZERO_FILL_EN
      if (w_accept) begin
        for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      end
`endif
      if (w_resp_wr) r_buf[r_received[IDX_W-1:0]] <= memData;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: in-order memory model with configurable latency and
// back-pressure, tile-level reference model and per-cycle output compare.
module tb_load_unit;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BD = 1024;
`ifdef LOAD_ZERO_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 loadEnable = 1'b0;
  logic [AW-1:0]        loadAddr = '0;
  logic [DW-1:0]        loadSize = '0;
  logic signed [DW-1:0] loadOut [0:BD-1];
  logic                 loadDone, busy, memRead;
  logic [AW-1:0]        memAddr;
  logic                 memReady;
  logic signed [DW-1:0] memData;
  logic                 memValid;

  always #5 clk = ~clk;

  load_unit dut (
    .clk(clk), .reset(reset), .loadEnable(loadEnable), .loadAddr(loadAddr),
    .loadSize(loadSize), .loadOut(loadOut), .loadDone(loadDone), .busy(busy),
    .memAddr(memAddr), .memRead(memRead), .memReady(memReady),
    .memData(memData), .memValid(memValid)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // stimulus-owned knobs
  int test_no = 0;
  int exp_lat = -1;
  int tmo_cnt = 0;
  int lat_lo  = 1;
  int lat_hi  = 1;
  bit rdy_rand = 1'b0;

  // memory responder: accepted reads return in order after lat_lo..lat_hi cycles
  logic [AW-1:0] q_addr [$];
  int            q_due  [$];
  bit            xfer;
  logic [AW-1:0] xaddr;
  int            mcyc = 0;

  initial begin
    memReady = 1'b0;
    memValid = 1'b0;
    memData  = '0;
    forever begin
      @(negedge clk);
      xfer  = memRead && memReady;
      xaddr = memAddr;
      @(posedge clk);
      #1;
      mcyc++;
      if (xfer) begin
        q_addr.push_back(xaddr);
        q_due.push_back(mcyc + $urandom_range(lat_hi, lat_lo) - 1);
      end
      if (q_due.size() > 0 && mcyc >= q_due[0]) begin
        memValid = 1'b1;
        memData  = memf(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        memValid = 1'b0;
      end
      memReady = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // compare-owned model state
  int                   nvec = 0;
  int                   nfail = 0;
  int                   nc = 0;
  int                   acc_nc = 0;
  int                   tmo_seen = 0;
  bit                   pending = 1'b0;
  bit                   prev_done = 1'b0;
  int                   m_issued = 0;
  int                   m_count = 0;
  logic [AW-1:0]        m_base = '0;
  longint               sq;
  logic signed [DW-1:0] exp_buf [0:BD-1];
  logic [AW-1:0]        wrap_addrs [0:3] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic buf_check(input string nm);
    int bad = -1;
    int idx;
    for (int i = 0; i < BD; i++) if (bad < 0 && loadOut[i] !== exp_buf[i]) bad = i;
    idx = (bad < 0) ? 0 : bad;
    chk(bad < 0, $sformatf("%s[%0d]", nm, idx), 64'($unsigned(loadOut[idx])),
        64'($unsigned(exp_buf[idx])));
  endtask

  initial for (int i = 0; i < BD; i++) exp_buf[i] = '0;

  always @(negedge clk) begin
    nc++;
    if (tmo_cnt != tmo_seen) begin
      chk(tmo_cnt == tmo_seen, "done_timeout", 64'(tmo_cnt), 64'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
    if (!reset) begin
      pending   = 1'b0;
      prev_done = 1'b0;
      for (int i = 0; i < BD; i++) exp_buf[i] = '0;
      chk(!busy && !loadDone && !memRead && memAddr == '0, "reset_outputs",
          {busy, loadDone, memRead, memAddr}, 64'd0);
      buf_check("reset_buf");
    end else begin
      chk(busy == pending, "busy", 64'(busy), 64'(pending));
      chk(memRead == (pending && m_issued < m_count), "memRead", 64'(memRead),
          64'(pending && m_issued < m_count));
      if (memRead) chk(memAddr == AW'(int'(m_base) + m_issued), "memAddr",
                       64'(memAddr), 64'(AW'(int'(m_base) + m_issued)));
      if (test_no == 5 && memRead && memReady && m_issued < 4)
        chk(memAddr == wrap_addrs[m_issued], "wrap_addr", 64'(memAddr), 64'(wrap_addrs[m_issued]));
      if (!busy) buf_check("idle_buf");
      if (loadDone) begin
        chk(pending && !prev_done, "done_pulse", {pending, prev_done}, 64'b10);
        chk(m_issued == m_count, "read_count", 64'(m_issued), 64'(m_count));
        buf_check("tile_buf");
        if (exp_lat >= 0) chk(nc - acc_nc == exp_lat, "done_latency", 64'(nc - acc_nc), 64'(exp_lat));
        case (test_no)
          1: begin
            chk(loadOut[0] == 16'hA4C3, "t1_out0", 64'($unsigned(loadOut[0])), 64'h A4C3);
            chk(loadOut[8] == 16'hA4CB, "t1_out8", 64'($unsigned(loadOut[8])), 64'h A4CB);
          end
          2: chk(m_issued == 0, "t2_no_reads", 64'(m_issued), 64'd0);
          3: chk(loadOut[24] == 16'hA7DB, "t3_out24", 64'($unsigned(loadOut[24])), 64'hA7DB);
          4: begin
            chk(loadOut[0] == 16'hA6C3, "t4_out0", 64'($unsigned(loadOut[0])), 64'hA6C3);
            chk(loadOut[9] == (FILL ? 16'h0000 : 16'hA7CA), "t4_out9",
                64'($unsigned(loadOut[9])), FILL ? 64'h0 : 64'hA7CA);
            chk(loadOut[24] == (FILL ? 16'h0000 : 16'hA7DB), "t4_out24",
                64'($unsigned(loadOut[24])), FILL ? 64'h0 : 64'hA7DB);
          end
          5: begin
            chk(loadOut[2] == 16'hA5C3, "t5_out2", 64'($unsigned(loadOut[2])), 64'hA5C3);
            chk(loadOut[3] == 16'hA5C2, "t5_out3", 64'($unsigned(loadOut[3])), 64'hA5C2);
          end
          6: begin
            chk(m_issued == 784, "t6_reads", 64'(m_issued), 64'd784);
            chk(loadOut[783] == 16'h86CC, "t6_out783", 64'($unsigned(loadOut[783])), 64'h86CC);
          end
          7: begin
            chk(m_issued == 1024, "t7_reads", 64'(m_issued), 64'd1024);
            chk(loadOut[1023] == 16'hB63C, "t7_out1023", 64'($unsigned(loadOut[1023])), 64'hB63C);
          end
          9: begin
            chk(loadOut[3] == 16'hA0C0, "t9_out3", 64'($unsigned(loadOut[3])), 64'hA0C0);
            chk(loadOut[4] == 16'h0000, "t9_out4", 64'($unsigned(loadOut[4])), 64'h0);
          end
          default: ;
        endcase
        pending = 1'b0;
      end
      prev_done = loadDone;
      if (memRead && memReady) m_issued++;
      if (!busy && loadEnable) begin
        sq       = longint'(loadSize) * longint'(loadSize);
        m_count  = (sq > BD) ? BD : int'(sq);
        m_base   = loadAddr;
        m_issued = 0;
        pending  = 1'b1;
        acc_nc   = nc;
        if (FILL) for (int i = 0; i < BD; i++) exp_buf[i] = '0;
        for (int i = 0; i < m_count; i++) exp_buf[i] = memf(loadAddr + AW'(i));
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (loadDone) return;
    end
    tmo_cnt++;
  endtask

  task automatic request(input int tn, input logic [AW-1:0] a, input logic [DW-1:0] n, input int lat);
    @(posedge clk);
    #1;
    test_no    = tn;
    exp_lat    = lat;
    loadAddr   = a;
    loadSize   = n;
    loadEnable = 1'b1;
    @(posedge clk);
    #1;
    loadEnable = 1'b0;
  endtask

  int nreads;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // N=3 at 0x0100, single-cycle latency; loadDone seen 11 edges after acceptance
    request(1, 16'h0100, 16'd3, 11);
    wait_done(100);
    // N=0: DONE entered straight from IDLE, no reads
    request(2, 16'h0040, 16'd0, 1);
    wait_done(20);
    // N=5 then immediately N=3: entries 9..24 keep or clear per build
    lat_lo = 1; lat_hi = 3;
    request(3, 16'h0200, 16'd5, -1);
    wait_done(200);
    request(4, 16'h0300, 16'd3, -1);
    wait_done(200);
    // address wrap
    lat_lo = 1; lat_hi = 2;
    request(5, 16'hFFFE, 16'd2, -1);
    wait_done(100);
    // N=28 with random back-pressure and latency 1..6
    rdy_rand = 1'b1; lat_lo = 1; lat_hi = 6;
    request(6, 16'h2000, 16'd28, -1);
    wait_done(6000);
    // N=40 clamps to the full buffer
    rdy_rand = 1'b0; lat_lo = 1; lat_hi = 2;
    request(7, 16'h1000, 16'd40, -1);
    wait_done(3000);

    // reset in the middle of an N=4 load, with responses still in flight
    lat_lo = 4; lat_hi = 4;
    request(8, 16'h0400, 16'd4, -1);
    nreads = 0;
    for (int k = 0; k < 200 && nreads < 10; k++) begin
      @(negedge clk);
      if (memRead && memReady) nreads++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 50 && q_addr.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);

    lat_lo = 1; lat_hi = 3;
    request(9, 16'h0500, 16'd2, -1);
    wait_done(200);

    test_no = 0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
